// File: rtl/hazard_unit.sv
// hazard_unit: in-flight destination scoreboard that stalls decode on RAW hazards and squashes after redirects.
// Optional feature macro: HAZARD_FWD_EN (bypass select, stall on load-use only).
module hazard_unit #(
    parameter int  REG_ADDR_W = 4,
    parameter int  DEPTH      = 3,
    parameter int  BR_PENALTY = 2,
    localparam int FWD_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_s1_addr,
    input  logic [REG_ADDR_W-1:0] id_s2_addr,
    input  logic                  id_s1_used,
    input  logic                  id_s2_used,
    input  logic [REG_ADDR_W-1:0] id_d_addr,
    input  logic                  id_reg_wrt_en,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    output logic                  stall_out,
    output logic                  flush_out,
    output logic [FWD_W-1:0]      fwd_s1_sel,
    output logic [FWD_W-1:0]      fwd_s2_sel
);

    localparam int CNT_W = $clog2(BR_PENALTY + 1);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]                           state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [DEPTH-1:0]                     ev_q, ev_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]     ea_q, ea_d;
    logic [DEPTH-1:0]                     m1_s, m2_s;
    logic                                 hazard_s;
    logic                                 issue_s;

    assign flush_out = ex_redirect | (state_q == ST_FLUSH);
    assign stall_out = id_valid & ~flush_out & hazard_s;
    assign issue_s   = id_valid & id_reg_wrt_en & ~stall_out & ~flush_out;

    // Source-versus-entry address matches for every tracked stage
    always_comb begin
        m1_s = '0;
        m2_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m1_s[k] = id_s1_used & ev_q[k] & (ea_q[k] == id_s1_addr);
            m2_s[k] = id_s2_used & ev_q[k] & (ea_q[k] == id_s2_addr);
        end
    end

    // Scoreboard shift: stalled or squashed decode slots enter EX as bubbles
    always_comb begin
        ev_d    = ev_q;
        ea_d    = ea_q;
        ev_d[0] = issue_s;
        ea_d[0] = id_d_addr;
        for (int k = 1; k < DEPTH; k++) begin
            ev_d[k] = ev_q[k-1];
            ea_d[k] = ea_q[k-1];
        end
    end

`ifdef HAZARD_FWD_EN
    logic [DEPTH-1:0] el_q, el_d;
    logic [FWD_W-1:0] sel1_s, sel2_s;

    // Load flag travels alongside the scoreboard entry
    always_comb begin
        el_d    = el_q;
        el_d[0] = id_is_load;
        for (int k = 1; k < DEPTH; k++) begin
            el_d[k] = el_q[k-1];
        end
    end

    // Only a load still in EX cannot be bypassed
    always_comb begin
        hazard_s = (m1_s[0] | m2_s[0]) & el_q[0];
    end

    // Youngest matching producer wins, so scan oldest to youngest
    always_comb begin
        sel1_s = '0;
        sel2_s = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m1_s[k]) begin
                sel1_s = FWD_W'(k + 1);
            end else begin
                sel1_s = sel1_s;
            end
            if (m2_s[k]) begin
                sel2_s = FWD_W'(k + 1);
            end else begin
                sel2_s = sel2_s;
            end
        end
    end

    assign fwd_s1_sel = sel1_s;
    assign fwd_s2_sel = sel2_s;

    // Load-flag storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            el_q <= '0;
        end else begin
            el_q <= el_d;
        end
    end
`else
    logic unused_is_load_s;
    assign unused_is_load_s = id_is_load;

    // Without bypassing, any in-flight writer of a source blocks issue
    always_comb begin
        hazard_s = (|m1_s) | (|m2_s);
    end

    assign fwd_s1_sel = '0;
    assign fwd_s2_sel = '0;
`endif

    // Redirect squash sequencer; a redirect while flushing restarts the window
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    cnt_d   = CNT_W'(BR_PENALTY - 1);
                    state_d = (BR_PENALTY > 1) ? ST_FLUSH : ST_RUN;
                end else begin
                    cnt_d   = cnt_q;
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (ex_redirect) begin
                    cnt_d   = CNT_W'(BR_PENALTY - 1);
                    state_d = ST_FLUSH;
                end else if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    // State and scoreboard registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ev_q    <= '0;
            ea_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            ea_q    <= ea_d;
        end
    end

endmodule
